hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage RISC-V datapath. It detects load-use hazards, branch/jump redirects and data-memory wait states, and drives the enable/clear controls of the stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the EX-stage forwarding selects. It also keeps saturating stall and flush performance counters, and runs a watchdog that flags a data memory that never returns ready.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for a 5-stage RISC-V pipeline: load-use/redirect/memory-wait
// handling, EX forwarding selects, saturating perf counters and a memory watchdog.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FreezeEMW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             MemTimeout,
  output logic             WaitState
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      WAIT_LIMIT = 16'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic        lw_stall, mem_wait, freeze;

  // Memory stage has priority over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Hazard detection, stage controls and forwarding selects (zero-latency).
  always_comb begin
    lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    mem_wait  = MemAccessM && !MemReadyM;
    freeze    = mem_wait || (state == ST_ERROR);
    StallF    = lw_stall || freeze;
    StallD    = lw_stall || freeze;
    FreezeEMW = freeze;
    FlushD    = PCSrcE && !freeze;
    FlushE    = (lw_stall || PCSrcE) && !freeze;
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Watchdog FSM next state: counts consecutive not-ready cycles.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_RUN: begin
        if (mem_wait) begin
          state_next    = ST_WAIT;
          wait_cnt_next = 16'd1;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (!mem_wait) begin
          state_next = ST_RUN;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_next = ST_ERROR;
        end else begin
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      ST_ERROR: begin
        state_next = ST_ERROR;
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = 16'd0;
      end
    endcase
  end

  // State, watchdog flags and saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      wait_cnt   <= 16'd0;
      StallCount <= {CNT_W{1'b0}};
      FlushCount <= {CNT_W{1'b0}};
      MemTimeout <= 1'b0;
      WaitState  <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      MemTimeout <= MemTimeout || (state_next == ST_ERROR);
      WaitState  <= (state_next == ST_WAIT);
      if (StallD && (StallCount != CNT_MAX)) begin
        StallCount <= StallCount + CNT_ONE;
      end
      if (FlushD && (FlushCount != CNT_MAX)) begin
        FlushCount <= FlushCount + CNT_ONE;
      end
    end
  end

endmodule
